// File: rtl/vec_mem_sequencer.sv
// Sequences one vector load/store as LANES element accesses on a single memory port, stalling upstream meanwhile.
// Loads assemble returned elements into one vector and write it to the VRF; outputs decode from registered state only.
module vec_mem_sequencer #(
  parameter int LANES  = 4,
  parameter int ELEM_W = 16,
  parameter int ADDR_W = 16,
  parameter int RD_LAT = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_store,
  input  logic [ADDR_W-1:0]       req_base,
  input  logic [ADDR_W-1:0]       req_stride,
  input  logic [LANES*ELEM_W-1:0] req_wdata,
  output logic [ADDR_W-1:0]       mem_addr,
  output logic                    mem_re,
  output logic                    mem_we,
  output logic [ELEM_W-1:0]       mem_wdata,
  input  logic [ELEM_W-1:0]       mem_rdata,
  output logic                    stall,
  output logic                    vrf_we,
  output logic [LANES*ELEM_W-1:0] vrf_wdata,
  output logic                    done
);

  localparam int IDX_W = $clog2(LANES);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_e;

  state_e                        state_q, state_d;
  logic                          store_q;
  logic [ADDR_W-1:0]             addr_q;
  logic [ADDR_W-1:0]             stride_q;
  logic [LANES-1:0][ELEM_W-1:0]  wdata_q;
  logic [LANES-1:0][ELEM_W-1:0]  buf_q;
  logic [IDX_W-1:0]              i_q;
  logic [IDX_W-1:0]              r_q;
  logic [RD_LAT-1:0]             rvld_q;
  logic [RD_LAT-1:0]             rvld_d;
  logic                          cap;
  logic                          last_issue;
  logic                          last_cap;

  // Outstanding-read tracker: the top bit marks the cycle the matching data is on mem_rdata.
  if (RD_LAT == 1) begin : g_lat1
    assign rvld_d = mem_re;
  end else begin : g_latn
    assign rvld_d = {rvld_q[RD_LAT-2:0], mem_re};
  end

  assign cap        = rvld_q[RD_LAT-1] && (state_q == S_ISSUE || state_q == S_WAIT);
  assign last_issue = (i_q == IDX_W'(LANES - 1));
  assign last_cap   = cap && (r_q == IDX_W'(LANES - 1));

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (req_valid) state_d = S_ISSUE;
      S_ISSUE: if (last_issue) state_d = store_q ? S_DONE : S_WAIT;
      S_WAIT:  if (last_cap) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready = 1'b0;
    stall     = 1'b0;
    mem_addr  = '0;
    mem_re    = 1'b0;
    mem_we    = 1'b0;
    mem_wdata = '0;
    vrf_we    = 1'b0;
    vrf_wdata = '0;
    done      = 1'b0;
    case (state_q)
      S_IDLE:  req_ready = 1'b1;
      S_ISSUE: begin
        stall     = 1'b1;
        mem_addr  = addr_q;
        mem_we    = store_q;
        mem_re    = !store_q;
        mem_wdata = store_q ? wdata_q[i_q] : '0;
      end
      S_WAIT:  stall = 1'b1;
      S_DONE:  begin
        done      = 1'b1;
        vrf_we    = !store_q;
        vrf_wdata = store_q ? '0 : buf_q;
      end
      default: ;
    endcase
  end

  // Clearing the tracker on reset is what drops reads still in flight from an aborted load.
  always_ff @(posedge clk) begin
    if (rst) begin
      store_q  <= 1'b0;
      addr_q   <= '0;
      stride_q <= '0;
      wdata_q  <= '0;
      buf_q    <= '0;
      i_q      <= '0;
      r_q      <= '0;
      rvld_q   <= '0;
    end else begin
      rvld_q <= rvld_d;
      if (state_q == S_IDLE && req_valid) begin
        store_q  <= req_store;
        addr_q   <= req_base;
        stride_q <= req_stride;
        wdata_q  <= req_wdata;
        buf_q    <= '0;
        i_q      <= '0;
        r_q      <= '0;
      end
      if (state_q == S_ISSUE) begin
        addr_q <= addr_q + stride_q;
        i_q    <= i_q + IDX_W'(1);
      end
      if (cap) begin
        buf_q[r_q] <= mem_rdata;
        r_q        <= r_q + IDX_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_vec_mem_sequencer.sv
// Directed bench for vec_mem_sequencer (LANES=4, RD_LAT=2): table of ops plus reset-abort and held-valid sequences.
module tb_vec_mem_sequencer;
  localparam int LANES  = 4;
  localparam int ELEM_W = 16;
  localparam int ADDR_W = 16;
  localparam int RD_LAT = 2;

  logic                    clk;
  logic                    rst;
  logic                    req_valid;
  logic                    req_ready;
  logic                    req_store;
  logic [ADDR_W-1:0]       req_base;
  logic [ADDR_W-1:0]       req_stride;
  logic [LANES*ELEM_W-1:0] req_wdata;
  logic [ADDR_W-1:0]       mem_addr;
  logic                    mem_re;
  logic                    mem_we;
  logic [ELEM_W-1:0]       mem_wdata;
  logic [ELEM_W-1:0]       mem_rdata;
  logic                    stall;
  logic                    vrf_we;
  logic [LANES*ELEM_W-1:0] vrf_wdata;
  logic                    done;

  int checks;
  int failures;

  typedef struct packed {
    logic                   store;
    logic [15:0]            base;
    logic [15:0]            stride;
    logic [63:0]            wdata;
    logic [3:0][15:0]       addr;
    logic [63:0]            vrf;
  } vec_t;

  vec_t tbl [6];

  vec_mem_sequencer #(
    .LANES(LANES), .ELEM_W(ELEM_W), .ADDR_W(ADDR_W), .RD_LAT(RD_LAT)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
    .req_base(req_base), .req_stride(req_stride), .req_wdata(req_wdata),
    .mem_addr(mem_addr), .mem_re(mem_re), .mem_we(mem_we),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .stall(stall), .vrf_we(vrf_we), .vrf_wdata(vrf_wdata), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: returns addr^0xA000 exactly RD_LAT cycles after mem_re, 0xDEAD otherwise.
  logic [ELEM_W-1:0] rpipe [RD_LAT];
  always @(posedge clk) begin
    rpipe[0] <= mem_re ? (mem_addr ^ 16'hA000) : 16'hDEAD;
    for (int k = 1; k < RD_LAT; k++) rpipe[k] <= rpipe[k-1];
  end
  assign mem_rdata = rpipe[RD_LAT-1];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic st, input logic [15:0] b, input logic [15:0] s,
                              input logic [63:0] wd, input logic [63:0] ad, input logic [63:0] vr);
    vec_t v;
    v.store  = st;
    v.base   = b;
    v.stride = s;
    v.wdata  = wd;
    v.addr   = ad;
    v.vrf    = vr;
    return v;
  endfunction

  // Called at a negedge with the DUT idle; returns at the negedge of the idle cycle after DONE.
  task automatic run_op(input vec_t v, input bit hold, input string tag);
    int t;
    logic [5:0] exp_ctl;
    t = v.store ? LANES + 1 : LANES + RD_LAT + 1;
    chk($sformatf("%s c0 req_ready", tag), {63'd0, req_ready}, 64'd1);
    req_valid  = 1'b1;
    req_store  = v.store;
    req_base   = v.base;
    req_stride = v.stride;
    req_wdata  = v.wdata;
    for (int c = 1; c <= t + 1; c++) begin
      @(negedge clk);
      if (!hold) req_valid = 1'b0;
      exp_ctl = {c == t + 1, c < t, !v.store && c <= LANES, v.store && c <= LANES,
                 c == t, !v.store && c == t};
      chk($sformatf("%s c%0d ctl{rdy,stall,re,we,done,vrf_we}", tag, c),
          {58'd0, req_ready, stall, mem_re, mem_we, done, vrf_we}, {58'd0, exp_ctl});
      if (c <= LANES) begin
        chk($sformatf("%s c%0d mem_addr", tag, c), {48'd0, mem_addr}, {48'd0, v.addr[c-1]});
        chk($sformatf("%s c%0d mem_wdata", tag, c), {48'd0, mem_wdata},
            v.store ? {48'd0, v.wdata[(c-1)*16 +: 16]} : 64'd0);
      end
      chk($sformatf("%s c%0d vrf_wdata", tag, c), vrf_wdata,
          (!v.store && c == t) ? v.vrf : 64'd0);
    end
  endtask

  initial begin
    vec_t rl;
    checks     = 0;
    failures   = 0;
    tbl[0] = mk(1'b1, 16'h0100, 16'h0002, 64'h4444_3333_2222_1111,
                64'h0106_0104_0102_0100, 64'h0);
    tbl[1] = mk(1'b0, 16'h0010, 16'h0001, 64'h0,
                64'h0013_0012_0011_0010, 64'hA013_A012_A011_A010);
    tbl[2] = mk(1'b0, 16'hFFFE, 16'h0001, 64'h0,
                64'h0001_0000_FFFF_FFFE, 64'hA001_A000_5FFF_5FFE);
    tbl[3] = mk(1'b1, 16'h0200, 16'h0000, 64'h5678_1234_CAFE_BEEF,
                64'h0200_0200_0200_0200, 64'h0);
    tbl[4] = mk(1'b0, 16'h0033, 16'h0000, 64'h0,
                64'h0033_0033_0033_0033, 64'hA033_A033_A033_A033);
    tbl[5] = mk(1'b1, 16'hFFFF, 16'hFFFF, 64'h0004_0003_0002_0001,
                64'hFFFC_FFFD_FFFE_FFFF, 64'h0);
    rl = mk(1'b0, 16'h0080, 16'h0001, 64'h0,
            64'h0083_0082_0081_0080, 64'hA083_A082_A081_A080);

    rst        = 1'b1;
    req_valid  = 1'b0;
    req_store  = 1'b0;
    req_base   = '0;
    req_stride = '0;
    req_wdata  = '0;
    repeat (2) @(negedge clk);
    chk("reset ctl{rdy,stall,re,we,done,vrf_we}",
        {58'd0, req_ready, stall, mem_re, mem_we, done, vrf_we}, 64'h20);
    chk("reset vrf_wdata", vrf_wdata, 64'd0);
    chk("reset mem_addr", {48'd0, mem_addr}, 64'd0);
    rst = 1'b0;

    for (int i = 0; i < 6; i++) run_op(tbl[i], 1'b0, $sformatf("vec%0d", i));

    // req_valid held high across alternating store/load requests.
    run_op(tbl[0], 1'b1, "hold0");
    run_op(tbl[1], 1'b1, "hold1");
    run_op(tbl[3], 1'b1, "hold2");
    run_op(tbl[4], 1'b1, "hold3");
    req_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("hold idle%0d ctl", c),
          {58'd0, req_ready, stall, mem_re, mem_we, done, vrf_we}, 64'h20);
    end

    // Reset in cycle 3 of a load, then an immediate new load while stale reads return.
    req_valid  = 1'b1;
    req_store  = 1'b0;
    req_base   = 16'h0040;
    req_stride = 16'h0001;
    req_wdata  = '0;
    @(negedge clk);
    req_valid = 1'b0;
    chk("abort c1 ctl", {58'd0, req_ready, stall, mem_re, mem_we, done, vrf_we}, 64'h18);
    chk("abort c1 mem_addr", {48'd0, mem_addr}, 64'h0040);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort c4 ctl", {58'd0, req_ready, stall, mem_re, mem_we, done, vrf_we}, 64'h20);
    chk("abort c4 vrf_wdata", vrf_wdata, 64'd0);
    chk("abort c4 mem_addr", {48'd0, mem_addr}, 64'd0);
    rst = 1'b0;
    run_op(rl, 1'b0, "after_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
